// File: rtl/delay_mem_scheduler.sv
// ---------------------------------------------------------------------------
// delay_mem_scheduler
//   Per-sample sequencer and sole owner of the shared single-port delay-line
//   memory (fpga_sck domain). For every accepted start_sample it writes the
//   new ADC sample at the write pointer, then reads the main tap and,
//   optionally, the chorus and reverb taps. The captured taps are presented
//   together with a one-cycle sample_ready pulse.
//
// Ports
//   clk, reset          sample clock; asynchronous active-high reset
//   start_sample        one-cycle frame start strobe
//   sample_in           ADC word, sampled with start_sample
//   chorus_on/reverb_on tap enables, latched at frame start
//   chorus_delay        chorus tap distance behind the write pointer
//   mem_we/addr/wdata   memory command port
//   mem_rdata           memory read data (synchronous, one cycle latency)
//   main_q/chor_q/rev_q captured taps (disabled taps read as 0)
//   sample_ready        one-cycle pulse when *_q are updated
//   busy                frame in progress (WRITE..FLUSH)
//   overrun             sticky: start_sample seen while not idle
// ---------------------------------------------------------------------------
module delay_mem_scheduler #(
    parameter int SAMPLE_W  = 12,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int REV_DELAY = 12000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_sample,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                chorus_on,
    input  logic                reverb_on,
    input  logic [ADDR_W-1:0]   chorus_delay,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   main_q,
    output logic [DATA_W-1:0]   chor_q,
    output logic [DATA_W-1:0]   rev_q,
    output logic                sample_ready,
    output logic                busy,
    output logic                overrun
);

    localparam logic [ADDR_W-1:0] REV_OFF = ADDR_W'(REV_DELAY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_MAIN,
        S_RD_CHOR,
        S_RD_REV,
        S_FLUSH,
        S_DONE
    } state_t;

    // Which tap a read issued in a given cycle belongs to.
    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_MAIN,
        SLOT_CHOR,
        SLOT_REV
    } slot_t;

    state_t                r_state;
    state_t                w_next;
    slot_t                 r_pend;
    slot_t                 w_slot;

    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [ADDR_W-1:0]     w_addr_next;
    logic [SAMPLE_W-1:0]   r_sample;
    logic                  r_chor_on;
    logic                  r_rev_on;
    logic [ADDR_W-1:0]     r_chor_delay;
    logic                  r_overrun;

    logic [DATA_W-1:0]     r_sh_main;
    logic [DATA_W-1:0]     r_sh_chor;
    logic [DATA_W-1:0]     r_sh_rev;
    logic [DATA_W-1:0]     w_main_cap;
    logic [DATA_W-1:0]     w_chor_cap;
    logic [DATA_W-1:0]     w_rev_cap;

    logic [DATA_W-1:0]     r_main_q;
    logic [DATA_W-1:0]     r_chor_q;
    logic [DATA_W-1:0]     r_rev_q;

    // Next-state logic; tap skipping uses the per-frame latched enables.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start_sample) w_next = S_WRITE;
            S_WRITE:   w_next = S_RD_MAIN;
            S_RD_MAIN: begin
                if (r_chor_on)     w_next = S_RD_CHOR;
                else if (r_rev_on) w_next = S_RD_REV;
                else               w_next = S_FLUSH;
            end
            S_RD_CHOR: w_next = r_rev_on ? S_RD_REV : S_FLUSH;
            S_RD_REV:  w_next = S_FLUSH;
            S_FLUSH:   w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // mem_addr is registered against the state being entered, so it is
    // valid for the whole WRITE/RD_* cycle and holds elsewhere.
    always_comb begin
        w_addr_next = r_mem_addr;
        case (w_next)
            S_WRITE,
            S_RD_MAIN: w_addr_next = r_wr_ptr;
            S_RD_CHOR: w_addr_next = r_wr_ptr - r_chor_delay;
            S_RD_REV:  w_addr_next = r_wr_ptr - REV_OFF;
            default:   w_addr_next = r_mem_addr;
        endcase
    end

    always_comb begin
        w_slot = SLOT_NONE;
        case (r_state)
            S_RD_MAIN: w_slot = SLOT_MAIN;
            S_RD_CHOR: w_slot = SLOT_CHOR;
            S_RD_REV:  w_slot = SLOT_REV;
            default:   w_slot = SLOT_NONE;
        endcase
    end

    // The read still in flight during FLUSH is forwarded straight into the
    // output load so all three taps update on the same edge.
    always_comb begin
        w_main_cap = (r_pend == SLOT_MAIN) ? mem_rdata : r_sh_main;
        w_chor_cap = (r_pend == SLOT_CHOR) ? mem_rdata : r_sh_chor;
        w_rev_cap  = (r_pend == SLOT_REV)  ? mem_rdata : r_sh_rev;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pend       <= SLOT_NONE;
            r_wr_ptr     <= '0;
            r_mem_addr   <= '0;
            r_sample     <= '0;
            r_chor_on    <= 1'b0;
            r_rev_on     <= 1'b0;
            r_chor_delay <= '0;
            r_overrun    <= 1'b0;
            r_sh_main    <= '0;
            r_sh_chor    <= '0;
            r_sh_rev     <= '0;
            r_main_q     <= '0;
            r_chor_q     <= '0;
            r_rev_q      <= '0;
        end else begin
            r_state    <= w_next;
            r_mem_addr <= w_addr_next;
            r_pend     <= w_slot;

            if (start_sample) begin
                if (r_state == S_IDLE) begin
                    r_sample     <= sample_in;
                    r_chor_on    <= chorus_on;
                    r_rev_on     <= reverb_on;
                    r_chor_delay <= chorus_delay;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            case (r_pend)
                SLOT_MAIN: r_sh_main <= mem_rdata;
                SLOT_CHOR: r_sh_chor <= mem_rdata;
                SLOT_REV:  r_sh_rev  <= mem_rdata;
                default:   ;
            endcase

            if (r_state == S_FLUSH) begin
                r_main_q <= w_main_cap;
                r_chor_q <= r_chor_on ? w_chor_cap : '0;
                r_rev_q  <= r_rev_on  ? w_rev_cap  : '0;
            end

            if (r_state == S_DONE) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    assign mem_we       = (r_state == S_WRITE);
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = {{(DATA_W-SAMPLE_W){1'b0}}, r_sample};
    assign main_q       = r_main_q;
    assign chor_q       = r_chor_q;
    assign rev_q        = r_rev_q;
    assign sample_ready = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_delay_mem_scheduler.sv
// ---------------------------------------------------------------------------
// tb_delay_mem_scheduler
//   Drives two scheduler instances (default build, and a 4-bit address build
//   with a reverb distance of 3) against behavioural delay-line memories.
//   Expected tap values come from a model of the buffer contents indexed by
//   a model write pointer.
// ---------------------------------------------------------------------------
module tb_delay_mem_scheduler;

    localparam int RD_A = 12000;
    localparam int RD_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: default parameters ----------------
    logic        a_start = 1'b0, a_con = 1'b0, a_ron = 1'b0;
    logic [11:0] a_sin = '0;
    logic [15:0] a_cd = '0;
    logic        a_we, a_rdy, a_busy, a_ov;
    logic [15:0] a_addr, a_wdata, a_main, a_chor, a_rev;
    logic [15:0] a_rdata = '0;
    logic [15:0] mem_a [0:65535] = '{default: '0};

    delay_mem_scheduler dut_a (
        .clk(clk), .reset(rst), .start_sample(a_start), .sample_in(a_sin),
        .chorus_on(a_con), .reverb_on(a_ron), .chorus_delay(a_cd),
        .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
        .main_q(a_main), .chor_q(a_chor), .rev_q(a_rev),
        .sample_ready(a_rdy), .busy(a_busy), .overrun(a_ov)
    );

    always @(posedge clk) begin
        if (a_we) mem_a[a_addr] <= a_wdata;
        a_rdata <= mem_a[a_addr];
    end

    // ---------------- instance B: 16-word buffer ----------------
    logic        b_start = 1'b0;
    logic [11:0] b_sin = '0;
    logic [3:0]  b_cd = '0;
    logic        b_we, b_rdy, b_busy, b_ov;
    logic [3:0]  b_addr;
    logic [15:0] b_wdata, b_main, b_chor, b_rev;
    logic [15:0] b_rdata = '0;
    logic [15:0] mem_b [0:15] = '{default: '0};

    delay_mem_scheduler #(
        .SAMPLE_W(12), .DATA_W(16), .ADDR_W(4), .REV_DELAY(RD_B)
    ) dut_b (
        .clk(clk), .reset(rst), .start_sample(b_start), .sample_in(b_sin),
        .chorus_on(1'b0), .reverb_on(1'b1), .chorus_delay(b_cd),
        .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
        .main_q(b_main), .chor_q(b_chor), .rev_q(b_rev),
        .sample_ready(b_rdy), .busy(b_busy), .overrun(b_ov)
    );

    always @(posedge clk) begin
        if (b_we) mem_b[b_addr] <= b_wdata;
        b_rdata <= mem_b[b_addr];
    end

    // ---------------- reference model ----------------
    logic [15:0] m_mem [0:65535] = '{default: '0};
    logic [15:0] m_ptr = '0;
    logic        m_ov = 1'b0;
    logic [15:0] e_main = '0, e_chor = '0, e_rev = '0;
    logic [15:0] mb [0:15] = '{default: '0};
    logic [3:0]  pb = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_we",    32'(a_we),    32'd0);
        chk("rst_addr",  32'(a_addr),  32'd0);
        chk("rst_wdata", 32'(a_wdata), 32'd0);
        chk("rst_main",  32'(a_main),  32'd0);
        chk("rst_chor",  32'(a_chor),  32'd0);
        chk("rst_rev",   32'(a_rev),   32'd0);
        chk("rst_rdy",   32'(a_rdy),   32'd0);
        chk("rst_busy",  32'(a_busy),  32'd0);
        chk("rst_ov",    32'(a_ov),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_ptr = '0; m_ov = 1'b0;
        e_main = '0; e_chor = '0; e_rev = '0;
    endtask

    // One frame on instance A. extra != 0 pulses start_sample again in cycle k+extra.
    task automatic frame_a(input logic [11:0] s, input logic con, input logic ron,
                           input logic [15:0] cd, input int unsigned extra);
        int unsigned r, lat, n;
        logic [15:0] addrs [4];
        logic [15:0] ca, ra, nm, nc, nr;
        r   = 1 + 32'(con) + 32'(ron);
        lat = 3 + r;
        ca  = m_ptr - cd;
        ra  = m_ptr - 16'(RD_A);
        n   = 2;
        addrs[0] = m_ptr; addrs[1] = m_ptr; addrs[2] = '0; addrs[3] = '0;
        if (con) begin addrs[n] = ca; n++; end
        if (ron) addrs[n] = ra;
        // the write precedes the reads, so taps see this frame's sample
        m_mem[m_ptr] = {4'h0, s};
        nm = m_mem[m_ptr];
        nc = con ? m_mem[ca] : 16'h0;
        nr = ron ? m_mem[ra] : 16'h0;

        @(negedge clk);
        a_start = 1'b1; a_sin = s; a_con = con; a_ron = ron; a_cd = cd;
        for (int unsigned c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c <= r + 1) begin
                chk("mem_we",   32'(a_we),   32'(c == 1));
                chk("mem_addr", 32'(a_addr), 32'(addrs[c-1]));
            end
            if (c == 1) chk("mem_wdata", 32'(a_wdata), 32'({4'h0, s}));
            chk("ready", 32'(a_rdy),  32'(c == lat));
            chk("busy",  32'(a_busy), 32'(c < lat));
            if (c < lat) begin
                chk("hold_main", 32'(a_main), 32'(e_main));
                chk("hold_chor", 32'(a_chor), 32'(e_chor));
                chk("hold_rev",  32'(a_rev),  32'(e_rev));
            end else begin
                chk("main_q", 32'(a_main), 32'(nm));
                chk("chor_q", 32'(a_chor), 32'(nc));
                chk("rev_q",  32'(a_rev),  32'(nr));
            end
            a_start = (c == extra);
            if (c == 1) begin
                // inputs wander mid-frame; only the latched copies may matter
                a_sin = 12'($urandom); a_cd = 16'($urandom);
                a_con = ~con; a_ron = ~ron;
            end
        end
        @(negedge clk);
        a_start = 1'b0;
        if (extra != 0) m_ov = 1'b1;
        chk("overrun", 32'(a_ov), 32'(m_ov));
        m_ptr = m_ptr + 16'd1;
        e_main = nm; e_chor = nc; e_rev = nr;
    endtask

    initial begin
        logic [11:0] s;
        logic        con, ron;
        logic [15:0] cd;
        int unsigned sel, r, ex;
        logic [3:0]  rb;
        logic [15:0] bm, br;

        // reset state
        repeat (2) @(negedge clk);
        do_reset();

        // first frame: main tap only, write at address 0
        frame_a(12'hABC, 1'b0, 1'b0, 16'd0, 0);

        // ramp fill with chorus distance 5
        do_reset();
        for (int i = 0; i <= 20; i++) frame_a(12'(i), 1'b1, 1'b0, 16'd5, 0);
        chk("ramp_chor20", 32'(a_chor), 32'd15);
        chk("ramp_rev20",  32'(a_rev),  32'd0);

        // start during DONE counts as overrun
        frame_a(12'h123, 1'b0, 1'b0, 16'd3, 4);

        // both taps on, second start at k+2; overrun sticks
        do_reset();
        frame_a(12'h5A5, 1'b1, 1'b1, 16'd1, 2);
        frame_a(12'h00F, 1'b1, 1'b1, 16'd2, 0);

        // chorus_delay = 0 returns this frame's sample
        frame_a(12'h7E1, 1'b1, 1'b0, 16'd0, 0);

        // randomized frames
        for (int i = 0; i < 40; i++) begin
            s   = 12'($urandom);
            con = 1'($urandom);
            ron = 1'($urandom);
            sel = $urandom_range(0, 2);
            cd  = (sel == 0) ? 16'($urandom_range(0, 3)) :
                  (sel == 1) ? 16'($urandom_range(4, 40)) : 16'($urandom);
            r   = 1 + 32'(con) + 32'(ron);
            ex  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3 + r) : 0;
            frame_a(s, con, ron, cd, ex);
        end

        // reset mid-frame at k+3
        @(negedge clk);
        a_start = 1'b1; a_sin = 12'h9C3; a_con = 1'b1; a_ron = 1'b1; a_cd = 16'd4;
        @(negedge clk); a_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_we",   32'(a_we),   32'd0);
        chk("abort_addr", 32'(a_addr), 32'd0);
        chk("abort_main", 32'(a_main), 32'd0);
        chk("abort_chor", 32'(a_chor), 32'd0);
        chk("abort_rev",  32'(a_rev),  32'd0);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_ov",   32'(a_ov),   32'd0);
        m_mem[m_ptr] = 16'h09C3;   // the write of the aborted frame had completed
        @(negedge clk);
        rst = 1'b0;
        m_ptr = '0; m_ov = 1'b0; e_main = '0; e_chor = '0; e_rev = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(a_rdy), 32'd0);
            chk("abort_no_we",    32'(a_we),  32'd0);
        end
        frame_a(12'h321, 1'b1, 1'b1, 16'd1, 0);

        // instance B: reverb tap over a 16-word buffer, pointer wraps
        for (int f = 0; f < 18; f++) begin
            s  = 12'($urandom);
            mb[pb] = {4'h0, s};
            rb = pb - 4'(RD_B);
            bm = mb[pb];
            br = mb[rb];
            @(negedge clk);
            b_start = 1'b1; b_sin = s; b_cd = 4'($urandom);
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                b_start = 1'b0;
                b_sin = 12'($urandom);
                if (c == 1) begin
                    chk("b_we",    32'(b_we),    32'd1);
                    chk("b_waddr", 32'(b_addr),  32'(pb));
                end
                if (c == 2) chk("b_main_addr", 32'(b_addr), 32'(pb));
                if (c == 3) chk("b_rev_addr",  32'(b_addr), 32'(rb));
                chk("b_ready", 32'(b_rdy), 32'(c == 5));
                if (c == 5) begin
                    chk("b_main_q", 32'(b_main), 32'(bm));
                    chk("b_rev_q",  32'(b_rev),  32'(br));
                    chk("b_chor_q", 32'(b_chor), 32'd0);
                end
            end
            pb = pb + 4'd1;
        end
        chk("b_overrun", 32'(b_ov), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
